// File: rtl/nand_gate.sv
// Bitwise 2-input NAND leaf cell with a registered copy of the result,
// sticky input-combination coverage on bit 0 and a saturating toggle
// counter on bit 0 of the registered output.
module nand_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [3:0]       combo_seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] y_toggles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] y_p1;
  logic [3:0]       seen_p1;
  logic [CNT_W-1:0] toggles_p1;
  logic [1:0]       combo_p0;
  logic             flip_p0;

  // Increment that sticks at the all-ones ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  // Combinational NAND; deliberately untouched by clk and rst so X/Z
  // propagates with plain Verilog semantics and stays live during reset.
  always_comb begin
    y        = ~(a & b);
    combo_p0 = {a[0], b[0]};
    flip_p0  = y[0] ^ y_p1[0];
  end

  // Stage p0 -> p1: capture result, coverage and toggle count. Reset drives
  // y_q to the NAND of all-zero inputs so it matches an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p1       <= '1;
      seen_p1    <= 4'b0000;
      toggles_p1 <= '0;
    end else begin
      y_p1    <= y;
      seen_p1 <= seen_p1 | (4'b0001 << combo_p0);
      if (flip_p0) begin
        toggles_p1 <= sat_inc(toggles_p1);
      end
    end
  end

  // Outputs are straight views of the p1 registers; all_seen is decoded
  // combinationally so it rises in the same cycle coverage completes.
  always_comb begin
    y_q        = y_p1;
    combo_seen = seen_p1;
    all_seen   = &seen_p1;
    y_toggles  = toggles_p1;
  end

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate: directed scenarios followed by random
// stimulus with occasional asynchronous reset pulses, all compared against
// a truth-table / counting reference model.
module tb_nand_gate;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       combo_seen;
  logic             all_seen;
  logic [CNT_W-1:0] y_toggles;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [WIDTH-1:0] m_yq;
  bit               m_seen [4];
  int               m_tog;

  nand_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .y          (y),
    .y_q        (y_q),
    .combo_seen (combo_seen),
    .all_seen   (all_seen),
    .y_toggles  (y_toggles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-bit lookup in the NAND truth table (00->1, 01->1, 10->1, 11->0).
  function automatic logic [WIDTH-1:0] ref_nand(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [3:0] tt;
    logic [WIDTH-1:0] r;
    tt = 4'b0111;
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{av[i], bv[i]}];
    return r;
  endfunction

  task automatic model_reset();
    m_yq = '1;
    for (int k = 0; k < 4; k++) m_seen[k] = 1'b0;
    m_tog = 0;
  endtask

  task automatic check_state(input string tag);
    logic [3:0] es;
    for (int k = 0; k < 4; k++) es[k] = m_seen[k];
    chk({tag, ".y_q"}, 32'(y_q), 32'(m_yq));
    chk({tag, ".combo"}, 32'(combo_seen), 32'(es));
    chk({tag, ".all"}, 32'(all_seen), 32'(m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]));
    chk({tag, ".tog"}, 32'(y_toggles), 32'((m_tog > CMAX) ? CMAX : m_tog));
  endtask

  // One clock: drive at negedge, check y, let the edge happen, update the
  // model, then check the registered outputs just after the edge.
  task automatic step(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] ny;
    @(negedge clk);
    a = av;
    b = bv;
    #1;
    chk({tag, ".y"}, 32'(y), 32'(ref_nand(av, bv)));
    @(posedge clk);
    if (!rst) begin
      ny = ref_nand(av, bv);
      if (ny[0] != m_yq[0]) m_tog++;
      m_yq = ny;
      m_seen[{av[0], bv[0]}] = 1'b1;
    end
    #1;
    check_state(tag);
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    chk({tag, ".y_in_rst"}, 32'(y), 32'(ref_nand(a, b)));
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] pa [4];
  logic [WIDTH-1:0] pb [4];

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    model_reset();
    #3;
    check_state("reset");

    // combinational truth table during reset, all bits replicated
    pa[0] = '0; pa[1] = '0; pa[2] = '1; pa[3] = '1;
    pb[0] = '0; pb[1] = '1; pb[2] = '0; pb[3] = '1;
    for (int i = 0; i < 4; i++) begin
      a = pa[i];
      b = pb[i];
      #10;
      $display("t=%0t a=%h b=%h y=%h", $time, a, b, y);
      chk("tt.y", 32'(y), 32'(ref_nand(pa[i], pb[i])));
    end

    // edge with rst high must not sample
    step("rst_edge", 8'hFF, 8'hFF);

    @(negedge clk);
    rst = 1'b0;

    // registered path and toggles
    step("reg11", 8'hFF, 8'hFF);
    step("reg00", 8'h00, 8'h00);

    // coverage build-up, then a repeat of 11
    step("cov00", 8'h00, 8'h00);
    step("cov01", 8'h00, 8'h01);
    step("cov10", 8'h01, 8'h00);
    step("cov11", 8'h01, 8'h01);
    step("cov11r", 8'h01, 8'h01);

    // vector width
    step("vec", 8'hF0, 8'hAA);

    // saturation: alternate 11/00
    for (int i = 0; i < 6; i++)
      step("sat", (i % 2 == 0) ? 8'hFF : 8'h00, (i % 2 == 0) ? 8'hFF : 8'h00);

    rst_pulse("midrst");
    step("post_rst", 8'h3C, 8'h0F);

    // random traffic with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      step("rnd", WIDTH'($urandom), WIDTH'($urandom));
      if ($urandom_range(0, 39) == 0) rst_pulse("rndrst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Bitwise 2-input NAND primitive for the universal-gate library.
- Provides a combinational output plus a registered copy.
- Includes lightweight on-block observability: input-combination coverage flags and an output toggle counter on bit 0.
- Used as a leaf cell and as a self-checking demo element in gate-level test designs.

Parameters:
- WIDTH, 1, bit width of operands a, b and outputs y, y_q (must be >= 1)
- CNT_W, 16, width of the saturating toggle counter (must be >= 2)

Ports:
- clk  input  1  rising-edge clock for all registered state
- rst  input  1  asynchronous, active-high reset; clears all registered state
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- y  output  WIDTH  combinational result, y = ~(a & b)
- y_q  output  WIDTH  registered y, one-cycle latency
- combo_seen  output  4  sticky flags; bit k set once {a[0],b[0]} == k has been sampled
- all_seen  output  1  high when combo_seen == 4'b1111
- y_toggles  output  CNT_W  saturating count of bit-0 changes of y_q

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- y is purely combinational.
  - y[i] = NAND(a[i], b[i]) for every bit i.
  - Zero-cycle latency.
  - Independent of clk and rst; valid even while rst is asserted.
- Truth table per bit: 00->1, 01->1, 10->1, 11->0.
- X/Z on an input propagates per standard Verilog NAND semantics; no masking.
- y_q:
  - On each rising clk edge with rst low, y_q <= ~(a & b).
  - Reset value is all-ones, the NAND of all-zero inputs.
- combo_seen:
  - On each rising edge with rst low, bit {a[0],b[0]} is set.
  - Bits are sticky until reset. Reset value 4'b0000.
  - Only bit 0 of the operands feeds coverage.
- all_seen:
  - Combinational AND of the combo_seen bits.
  - Reset value 0.
  - Asserts in the same cycle combo_seen reaches 4'b1111.
- y_toggles:
  - On each rising edge with rst low, increments by 1 if the next y_q[0] differs from the current y_q[0].
  - Saturates at 2^CNT_W-1; no wrap.
  - Reset value 0.
- Reset:
  - Asserting rst at any time, including mid-sequence, immediately forces y_q to all-ones and clears combo_seen, all_seen and y_toggles, with no clock edge required.
  - y keeps tracking the inputs during reset.
  - Deassertion is not synchronised inside the block; the first edge after deassertion samples normally.
- Simultaneous events:
  - rst high at a clock edge wins; no sampling occurs.
  - Input changes between edges affect y immediately and registered state only at the next edge.
- No handshake and no state machine. All outputs are driven at all times.

Test Plan:
- Exhaustive combinational check, WIDTH=1, rst high: apply a,b = 00,01,10,11 with 10 time units each -> y = 1,1,1,0 after each step; log time, a, b and y on every change.
- Registered path: release rst, apply 11 then 00 on consecutive edges -> y_q = 1 during reset, 0 after the first edge, 1 after the second; y_toggles = 2.
- Coverage: drive 00,01,10,11 on four edges -> combo_seen goes 0001, 0011, 0111, 1111; all_seen rises on the fourth edge; a repeat of 11 leaves combo_seen unchanged.
- Mid-operation reset: after full coverage and y_toggles = 3, pulse rst between edges -> combo_seen = 0, all_seen = 0, y_toggles = 0 and y_q = 1 immediately; y still equals ~(a&b).
- Saturation with CNT_W=2: alternate 11/00 for 6 edges -> y_toggles reads 1, 2, 3, 3, 3, 3.
- Vector width, WIDTH=8: a=8'hF0, b=8'hAA -> y = 8'h5F combinationally; y_q = 8'h5F one edge later.
